// File: rtl/wg_ctrl_pkg.sv
// Shared types and helpers for the WorldGuard world-ID switch controller.
package wg_ctrl_pkg;

  // Switch sequencer states.
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    FLUSH,
    APPLY
  } wg_state_e;

  // CSR write targets, encoded as they arrive on csr_sel_i.
  typedef enum logic [1:0] {
    CSR_MLWID     = 2'b00,
    CSR_SLWID     = 2'b01,
    CSR_VSLWID    = 2'b10,
    CSR_MWIDDELEG = 2'b11
  } wg_csr_sel_e;

  // Privilege encodings.
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Width of a world ID for a given number of worlds (never zero).
  function automatic int unsigned wid_width(input int unsigned nr_worlds);
    return (nr_worlds > 1) ? $clog2(nr_worlds) : 1;
  endfunction

endpackage

// File: rtl/wg_wid_select.sv
// Combinational target world-ID mux: picks the WID the hart should run with
// from its privilege, virtualization mode and the lower-privilege registers.
module wg_wid_select
  import wg_ctrl_pkg::*;
#(
  parameter int unsigned NrWorlds = 128,
  parameter bit          SSWGEn   = 1'b1,
  parameter bit          SHWGEn   = 1'b1,
  localparam int unsigned WidW    = wid_width(NrWorlds)
) (
  input  logic [1:0]          priv_lvl,
  input  logic                v,
  input  logic [WidW-1:0]     mwid,
  input  logic [WidW-1:0]     mlwid,
  input  logic [WidW-1:0]     slwid,
  input  logic [WidW-1:0]     vslwid,
  input  logic [NrWorlds-1:0] mwiddeleg,
  output logic [WidW-1:0]     target_wid
);

  // Priority: M uses the platform WID, virtualized modes use vslwid,
  // delegated U-mode uses slwid, everything else falls back to mlwid.
  always_comb begin
    // NOTE: default assignment first so every path drives target_wid; no latch.
    target_wid = mlwid;
    if (priv_lvl == PRIV_M) begin
      target_wid = mwid;
    end else if (v) begin
      target_wid = SHWGEn ? vslwid : mlwid;
    end else if ((priv_lvl == PRIV_U) && SSWGEn && (|mwiddeleg)) begin
      target_wid = slwid;
    end
  end

endmodule

// File: rtl/wg_wid_switch_ctrl.sv
// WorldGuard world-ID controller for one hart: holds mlwid/slwid/vslwid and
// mwiddeleg, and sequences every effective-WID change through
// stall -> drain -> flush -> commit so no request is tagged with a stale WID.
module wg_wid_switch_ctrl
  import wg_ctrl_pkg::*;
#(
  parameter int unsigned NrWorlds = 128,
  parameter bit          SSWGEn   = 1'b1,
  parameter bit          SHWGEn   = 1'b1,
  localparam int unsigned WidW    = wid_width(NrWorlds)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          priv_lvl_i,
  input  logic                v_i,
  input  logic [WidW-1:0]     mwid_i,
  input  logic                csr_we_i,
  input  logic [1:0]          csr_sel_i,
  input  logic [NrWorlds-1:0] csr_wdata_i,
  output logic                csr_ready_o,
  output logic                csr_illegal_o,
  output logic [WidW-1:0]     mlwid_o,
  output logic [WidW-1:0]     slwid_o,
  output logic [WidW-1:0]     vslwid_o,
  output logic [NrWorlds-1:0] mwiddeleg_o,
  input  logic                mem_idle_i,
  output logic                flush_req_o,
  input  logic                flush_ack_i,
  output logic [WidW-1:0]     wid_o,
  output logic                wid_valid_o,
  output logic                stall_o
);

  wg_state_e           state_q;
  logic [WidW-1:0]     mlwid_q, slwid_q, vslwid_q;
  logic [NrWorlds-1:0] mwiddeleg_q;
  logic                illegal_q;
  logic [WidW-1:0]     wid_q, tgt_q;
  logic                wid_valid_q, stall_q, flush_req_q;
  logic [WidW-1:0]     target_wid;

  logic                wr_en;
  wg_csr_sel_e         wr_sel;
  logic [WidW-1:0]     wr_wid;
  logic                wr_delegated;

  // CSR writes are only accepted while no switch is in flight.
  assign wr_en        = csr_we_i && (state_q == IDLE);
  assign wr_sel       = wg_csr_sel_e'(csr_sel_i);
  assign wr_wid       = csr_wdata_i[WidW-1:0];
  assign wr_delegated = mwiddeleg_q[wr_wid];

  wg_wid_select #(
    .NrWorlds (NrWorlds),
    .SSWGEn   (SSWGEn),
    .SHWGEn   (SHWGEn)
  ) u_wid_select (
    .priv_lvl   (priv_lvl_i),
    .v          (v_i),
    .mwid       (mwid_i),
    .mlwid      (mlwid_q),
    .slwid      (slwid_q),
    .vslwid     (vslwid_q),
    .mwiddeleg  (mwiddeleg_q),
    .target_wid (target_wid)
  );

  // World-ID register file; rejected delegated writes raise a one-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      mlwid_q     <= '0;
      slwid_q     <= '0;
      vslwid_q    <= '0;
      mwiddeleg_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (wr_en) begin
        unique case (wr_sel)
          CSR_MLWID: mlwid_q <= wr_wid;
          CSR_SLWID: begin
            if (SSWGEn) begin
              if (wr_delegated) slwid_q   <= wr_wid;
              else              illegal_q <= 1'b1;
            end
          end
          CSR_VSLWID: begin
            if (SHWGEn) begin
              if (wr_delegated) vslwid_q  <= wr_wid;
              else              illegal_q <= 1'b1;
            end
          end
          CSR_MWIDDELEG: begin
            if (SSWGEn) mwiddeleg_q <= csr_wdata_i;
          end
          default: ;
        endcase
      end
    end
  end

  // Switch sequencer with registered stall/valid/flush outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      wid_q       <= '0;
      tgt_q       <= '0;
      wid_valid_q <= 1'b0;
      stall_q     <= 1'b1;
      flush_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          // Caches hold nothing after reset, so the first WID needs no flush.
          wid_q       <= target_wid;
          state_q     <= IDLE;
          wid_valid_q <= 1'b1;
          stall_q     <= 1'b0;
        end
        IDLE: begin
          if (target_wid != wid_q) begin
            tgt_q       <= target_wid;
            state_q     <= DRAIN;
            wid_valid_q <= 1'b0;
            stall_q     <= 1'b1;
          end
        end
        DRAIN: begin
          if (mem_idle_i) begin
            state_q     <= FLUSH;
            flush_req_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_ack_i) begin
            flush_req_q <= 1'b0;
            state_q     <= APPLY;
          end
        end
        APPLY: begin
          wid_q <= tgt_q;
          // A target that moved during the switch starts another full switch.
          if (target_wid != tgt_q) begin
            tgt_q   <= target_wid;
            state_q <= DRAIN;
          end else begin
            state_q     <= IDLE;
            wid_valid_q <= 1'b1;
            stall_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= INIT;
          wid_valid_q <= 1'b0;
          stall_q     <= 1'b1;
          flush_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_ready_o   = (state_q == IDLE);
  assign csr_illegal_o = illegal_q;
  assign mlwid_o       = mlwid_q;
  assign slwid_o       = slwid_q;
  assign vslwid_o      = vslwid_q;
  assign mwiddeleg_o   = mwiddeleg_q;
  assign flush_req_o   = flush_req_q;
  assign wid_o         = wid_q;
  assign wid_valid_o   = wid_valid_q;
  assign stall_o       = stall_q;

endmodule

// File: tb/tb_wg_wid_switch_ctrl.sv
// Directed bench for wg_wid_switch_ctrl. Stimulus pushes each expected WID
// commit into a queue; a monitor pops and compares on every wid_o change.
module tb_wg_wid_switch_ctrl;
  import wg_ctrl_pkg::*;

  localparam int unsigned NW = 128;
  localparam int unsigned WW = 7;

  logic          clk_i, rst_ni;
  logic [1:0]    priv_lvl_i;
  logic          v_i;
  logic [WW-1:0] mwid_i;
  logic          csr_we_i;
  logic [1:0]    csr_sel_i;
  logic [NW-1:0] csr_wdata_i;
  logic          csr_ready_o, csr_illegal_o;
  logic [WW-1:0] mlwid_o, slwid_o, vslwid_o;
  logic [NW-1:0] mwiddeleg_o;
  logic          mem_idle_i, flush_req_o, flush_ack_i;
  logic [WW-1:0] wid_o;
  logic          wid_valid_o, stall_o;

  wg_wid_switch_ctrl #(.NrWorlds(NW), .SSWGEn(1'b1), .SHWGEn(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .priv_lvl_i    (priv_lvl_i),
    .v_i           (v_i),
    .mwid_i        (mwid_i),
    .csr_we_i      (csr_we_i),
    .csr_sel_i     (csr_sel_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_ready_o   (csr_ready_o),
    .csr_illegal_o (csr_illegal_o),
    .mlwid_o       (mlwid_o),
    .slwid_o       (slwid_o),
    .vslwid_o      (vslwid_o),
    .mwiddeleg_o   (mwiddeleg_o),
    .mem_idle_i    (mem_idle_i),
    .flush_req_o   (flush_req_o),
    .flush_ack_i   (flush_ack_i),
    .wid_o         (wid_o),
    .wid_valid_o   (wid_valid_o),
    .stall_o       (stall_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int flush_cnt = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] prev_wid = '0;
  logic          prev_flush = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts flush_req rising edges and scores every WID commit.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_wid   = wid_o;
      prev_flush = flush_req_o;
    end else begin
      if (flush_req_o && !prev_flush) flush_cnt++;
      if (wid_o !== prev_wid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL commit_unexpected: got %0h, expected no commit", wid_o);
        end else begin
          check("commit_wid", wid_o, exp_q.pop_front());
        end
      end
      prev_wid   = wid_o;
      prev_flush = flush_req_o;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [NW-1:0] data);
    csr_we_i    = 1'b1;
    csr_sel_i   = sel;
    csr_wdata_i = data;
    cyc(1);
    csr_we_i    = 1'b0;
    csr_wdata_i = '0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!wid_valid_o && n < max_cyc);
    check("wid_valid_reached", wid_valid_o, 1);
  endtask

  task automatic wait_flush(input int max_cyc);
    int n = 0;
    while (!flush_req_o && n < max_cyc) begin
      cyc(1);
      n++;
    end
    check("flush_req_reached", flush_req_o, 1);
  endtask

  initial begin
    int n;
    int base;
    int held_bad;
    int flush_seen;

    rst_ni      = 1'b0;
    priv_lvl_i  = PRIV_M;
    v_i         = 1'b0;
    mwid_i      = 7'd5;
    csr_we_i    = 1'b0;
    csr_sel_i   = 2'b00;
    csr_wdata_i = '0;
    mem_idle_i  = 1'b1;
    flush_ack_i = 1'b1;

    // Reset state.
    cyc(3);
    check("rst_wid", wid_o, 0);
    check("rst_valid", wid_valid_o, 0);
    check("rst_stall", stall_o, 1);
    check("rst_flush_req", flush_req_o, 0);
    check("rst_csr_ready", csr_ready_o, 0);
    check("rst_illegal", csr_illegal_o, 0);
    check("rst_mwiddeleg", mwiddeleg_o, 0);

    // Reset release in M with mwid=5: INIT commits 5 without a flush.
    exp_q.push_back(7'd5);
    rst_ni = 1'b1;
    cyc(2);
    check("init_valid", wid_valid_o, 1);
    check("init_wid", wid_o, 5);
    check("init_stall", stall_o, 0);
    check("init_csr_ready", csr_ready_o, 1);
    check("init_no_flush", flush_cnt, 0);

    // mlwid=9 in M, then M->S: minimum four-cycle switch with one flush.
    csr_write(CSR_MLWID, 128'd9);
    check("mlwid_written", mlwid_o, 9);
    check("m_no_switch", wid_valid_o, 1);
    base = flush_cnt;
    exp_q.push_back(7'd9);
    priv_lvl_i = PRIV_S;
    wait_valid(20, n);
    check("switch_latency", n, 4);
    check("s_wid", wid_o, 9);
    check("s_flush_pulses", flush_cnt - base, 1);

    // Delegation: slwid=3 not delegated, slwid=4 delegated.
    csr_write(CSR_MWIDDELEG, 128'h10);
    check("deleg_written", mwiddeleg_o, 128'h10);
    csr_write(CSR_SLWID, 128'd3);
    check("slwid3_illegal", csr_illegal_o, 1);
    check("slwid3_kept", slwid_o, 0);
    cyc(1);
    check("illegal_one_cycle", csr_illegal_o, 0);
    csr_write(CSR_SLWID, 128'd4);
    check("slwid4_no_illegal", csr_illegal_o, 0);
    check("slwid4_written", slwid_o, 4);

    // S->U with memory busy: no flush and old WID held while draining.
    mem_idle_i = 1'b0;
    exp_q.push_back(7'd4);
    priv_lvl_i = PRIV_U;
    held_bad = 0;
    flush_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (flush_req_o) flush_seen++;
      if (wid_o !== 7'd9) held_bad++;
    end
    check("drain_no_flush", flush_seen, 0);
    check("drain_wid_held", held_bad, 0);
    check("drain_stall", stall_o, 1);
    mem_idle_i = 1'b1;
    wait_valid(20, n);
    check("u_wid", wid_o, 4);

    // Set up vslwid=7, return to S (wid 9).
    csr_write(CSR_MWIDDELEG, 128'h90);
    csr_write(CSR_VSLWID, 128'd7);
    check("vslwid_written", vslwid_o, 7);
    exp_q.push_back(7'd9);
    priv_lvl_i = PRIV_S;
    wait_valid(20, n);
    check("back_to_s_wid", wid_o, 9);

    // Target 4 -> 7 while in FLUSH: commit 4, then a second switch to 7.
    flush_ack_i = 1'b0;
    base = flush_cnt;
    exp_q.push_back(7'd4);
    exp_q.push_back(7'd7);
    priv_lvl_i = PRIV_U;
    wait_flush(20);
    v_i = 1'b1;
    cyc(2);
    check("flush_held_without_ack", flush_req_o, 1);
    check("flush_wid_old", wid_o, 9);
    flush_ack_i = 1'b1;
    wait_valid(30, n);
    check("retarget_wid", wid_o, 7);
    check("retarget_flush_pulses", flush_cnt - base, 2);

    // CSR write during DRAIN is refused.
    mem_idle_i = 1'b0;
    exp_q.push_back(7'd9);
    priv_lvl_i = PRIV_S;
    v_i = 1'b0;
    cyc(1);
    check("drain_csr_ready", csr_ready_o, 0);
    csr_write(CSR_MLWID, 128'd3);
    check("drain_mlwid_kept", mlwid_o, 9);
    check("drain_wid_old", wid_o, 7);

    // Reset while in FLUSH: flush_req drops at once, registers clear.
    flush_ack_i = 1'b0;
    mem_idle_i  = 1'b1;
    wait_flush(20);
    exp_q.delete();
    rst_ni = 1'b0;
    #1;
    check("midrst_flush_req", flush_req_o, 0);
    check("midrst_mlwid", mlwid_o, 0);
    check("midrst_slwid", slwid_o, 0);
    check("midrst_vslwid", vslwid_o, 0);
    check("midrst_mwiddeleg", mwiddeleg_o, 0);
    check("midrst_wid", wid_o, 0);
    check("midrst_valid", wid_valid_o, 0);
    check("midrst_stall", stall_o, 1);

    priv_lvl_i  = PRIV_M;
    flush_ack_i = 1'b1;
    cyc(2);
    base = flush_cnt;
    exp_q.push_back(7'd5);
    rst_ni = 1'b1;
    cyc(2);
    check("rerst_valid", wid_valid_o, 1);
    check("rerst_wid", wid_o, 5);
    cyc(3);
    check("rerst_no_flush", flush_cnt - base, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
